// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch prefetch buffer.
package ifetch_pkg;

   localparam int INST_BYTES = 4;
   localparam int FE_ADDR_W  = 32;
   localparam int FE_DATA_W  = 32;

   typedef struct packed {
      logic [FE_ADDR_W-1:0] pc;
      logic [FE_DATA_W-1:0] inst;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } ifetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries. clear wins over push and pop.
// The head is read combinationally so the consumer sees it the cycle after a push.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  entry_t                 push_data_i,
   input  logic                   pop_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o,
   output entry_t                 head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   // A push into a full FIFO is only legal alongside a pop.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Next pointer and occupancy values.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_ok && !pop_ok) count_d = count_q + (PTR_W+1)'(1);
         if (!push_ok && pop_ok) count_d = count_q - (PTR_W+1)'(1);
      end
   end

   // Storage array; no reset, occupancy decides what is visible.
   always_ff @(posedge clk_i) begin
      if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ifetch_prefetch_buf.sv
// Instruction-fetch front end: issues sequential fetches over a req/gnt/rvalid
// memory port and buffers {pc, inst} pairs for the datapath. A redirect flushes
// the buffer; responses already in flight are dropped by count.
// Optional macro IFETCH_PERF_EN adds saturating redirect/drop/stall counters.
module ifetch_prefetch_buf
   import ifetch_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC0_0000)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]       perf_flush_cnt_o,
   output logic [31:0]       perf_drop_cnt_o,
   output logic [31:0]       perf_stall_cnt_o
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);
   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);
   localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
   } buf_entry_t;

   ifetch_state_e     state_q;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic [CNT_W-1:0]  discard_q, discard_d;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;
   buf_entry_t        fifo_head, push_entry;
   logic              credit_ok, gnt, drop_rsp, push, pop;

   // Fetch slots are reserved at issue time, so every response has room.
   assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outst_q}) < CREDIT_MAX;
   assign mem_req_o  = !rst_i && (state_q != IDLE) && !redirect_i && credit_ok;
   assign mem_addr_o = rst_i ? (RESET_PC & ALIGN_MASK) : fetch_pc_q;
   assign gnt        = mem_req_o && mem_gnt_i;

   // Responses belonging to an abandoned stream (or landing on a redirect) are dropped.
   assign drop_rsp   = mem_rvalid_i && (redirect_i || (discard_q != '0));
   assign push       = mem_rvalid_i && !drop_rsp;
   assign push_entry = '{pc: rsp_pc_q, inst: mem_rdata_i};

   assign inst_valid_o = !rst_i && !fifo_empty;
   assign pop          = inst_valid_o && inst_ready_i;
   assign inst_o       = inst_valid_o ? fifo_head.inst : '0;
   assign inst_pc_o    = inst_valid_o ? fifo_head.pc   : '0;

   ifetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (buf_entry_t)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (redirect_i),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (fifo_head)
   );

   // Next-state for the address counters and in-flight bookkeeping; redirect dominates.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i & ALIGN_MASK;
         rsp_pc_d   = redirect_pc_i & ALIGN_MASK;
         outst_d    = outst_q - CNT_W'(mem_rvalid_i);
         discard_d  = outst_q - CNT_W'(mem_rvalid_i);
      end else begin
         if (gnt)      fetch_pc_d = fetch_pc_q + PC_STEP;
         if (push)     rsp_pc_d   = rsp_pc_q + PC_STEP;
         if (drop_rsp) discard_d  = discard_q - CNT_W'(1);
         outst_d = outst_q + CNT_W'(gnt) - CNT_W'(mem_rvalid_i);
      end
   end

   // Fetch FSM plus the counters it steers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC & ALIGN_MASK;
         rsp_pc_q   <= RESET_PC & ALIGN_MASK;
         outst_q    <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         case (state_q)
            IDLE:    state_q <= FETCH;
            FETCH:   if (redirect_i && (discard_d != '0)) state_q <= FLUSH;
            FLUSH:   if (!redirect_i && (discard_d == '0)) state_q <= FETCH;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_flush_q, perf_drop_q, perf_stall_q;

   assign perf_flush_cnt_o = perf_flush_q;
   assign perf_drop_cnt_o  = perf_drop_q;
   assign perf_stall_cnt_o = perf_stall_q;

   // Saturating event counters; a redirect does not clear them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_flush_q <= '0;
         perf_drop_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (redirect_i && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
         if (drop_rsp && (perf_drop_q != '1))    perf_drop_q  <= perf_drop_q + 32'd1;
         if (inst_ready_i && !inst_valid_o && (perf_stall_q != '1))
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Bench for ifetch_prefetch_buf: memory model with programmable latency,
// scoreboard of expected {pc, inst} pushed at grant time, popped on handshake.
module tb_ifetch_prefetch_buf;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst_i, redirect_i, inst_ready_i, mem_gnt_i, mem_rvalid_i;
   logic [31:0] redirect_pc_i, mem_rdata_i;
   logic        inst_valid_o, mem_req_o;
   logic [31:0] inst_o, inst_pc_o, mem_addr_o;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_flush_cnt_o, perf_drop_cnt_o, perf_stall_cnt_o;
`endif

   always #5 clk = ~clk;

   ifetch_prefetch_buf #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .inst_valid_o  (inst_valid_o),
      .inst_ready_i  (inst_ready_i),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i)
`ifdef IFETCH_PERF_EN
      ,
      .perf_flush_cnt_o (perf_flush_cnt_o),
      .perf_drop_cnt_o  (perf_drop_cnt_o),
      .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   pend_t       pend_q[$];
   logic [63:0] exp_q[$];
   logic [31:0] grant_log[$];
   vec_t        vecs[9];

   int          errors = 0, checks = 0;
   int          cyc = 0, lat = 1, disc_m = 0, pops = 0;
   logic        idle_m = 1'b1;
   logic [31:0] fpc_m = RST_PC;
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc;
   logic        seen_pop = 1'b0;
   logic [31:0] first_pc, first_inst;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   function automatic int fifo_m();
      return exp_q.size() - (pend_q.size() - disc_m);
   endfunction

   task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic check_bit(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%b required=%b", nm, act, exp);
      end
   endtask

   // One clock cycle: memory answers, outputs checked at the falling edge, model advanced.
   task automatic step();
      logic [63:0] e;
      int          fm;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (!rst_i && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = mem_word(pend_q[0].addr);
      end
      @(negedge clk);
      s_req = mem_req_o; s_addr = mem_addr_o; s_valid = inst_valid_o; s_pc = inst_pc_o;
      if (rst_i) begin
         check_bit("rst_valid", inst_valid_o, 1'b0);
         check_bit("rst_req", mem_req_o, 1'b0);
         check_val("rst_addr", mem_addr_o, RST_PC);
         check_val("rst_inst", inst_o, 32'h0);
         check_val("rst_pc", inst_pc_o, 32'h0);
         pend_q.delete(); exp_q.delete();
         disc_m = 0; idle_m = 1'b1; fpc_m = RST_PC;
      end else begin
         fm = fifo_m();
         check_bit("req", mem_req_o, !idle_m && !redirect_i && (fm + pend_q.size() < DEPTH));
         check_bit("valid", inst_valid_o, fm > 0);
         if (inst_valid_o && inst_ready_i) begin
            pops++;
            $display("pop pc=%h inst=%h", inst_pc_o, inst_o);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL pop_unexpected: actual pc=%h required none", inst_pc_o);
            end else begin
               e = exp_q.pop_front();
               check_val("head_pc", inst_pc_o, e[63:32]);
               check_val("head_inst", inst_o, e[31:0]);
            end
            if (!seen_pop) begin
               seen_pop = 1'b1; first_pc = inst_pc_o; first_inst = inst_o;
            end
         end
         if (mem_rvalid_i) begin
            void'(pend_q.pop_front());
            if (!redirect_i && disc_m > 0) disc_m--;
         end
         if (redirect_i) begin
            exp_q.delete();
            disc_m = pend_q.size();
            fpc_m  = redirect_pc_i & ~32'd3;
         end else if (mem_req_o && mem_gnt_i) begin
            check_val("fetch_addr", mem_addr_o, fpc_m);
            pend_q.push_back('{addr: mem_addr_o, due: cyc + lat});
            exp_q.push_back({fpc_m, mem_word(fpc_m)});
            grant_log.push_back(mem_addr_o);
            fpc_m = fpc_m + 32'd4;
         end
         idle_m = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst_i = 1'b1; redirect_i = 1'b0;
      for (int i = 0; i < n; i++) step();
      rst_i = 1'b0;
   endtask

   initial begin
      int p0, g0, gl0, disc_exp;
      bit found;
`ifdef IFETCH_PERF_EN
      logic [31:0] drop0;
`endif
      rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
      inst_ready_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

      // Startup with latency 1, grant always: exact cycle-by-cycle expectations.
      vecs[0] = '{1'b1, 1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0000};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0004};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_0008};
      vecs[8] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0014, 1'b1, 32'hBFC0_000C};
      lat = 1;
      for (int i = 0; i < 9; i++) begin
         rst_i = vecs[i].rst; inst_ready_i = vecs[i].rdy;
         step();
         check_bit("vec_req", s_req, vecs[i].exp_req);
         check_val("vec_addr", s_addr, vecs[i].exp_addr);
         check_bit("vec_valid", s_valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid || vecs[i].rst) check_val("vec_pc", s_pc, vecs[i].exp_pc);
      end

      // Back-pressure: only DEPTH fetches, then one request per pop.
      inst_ready_i = 1'b0;
      do_reset(2);
      g0 = grant_log.size();
      for (int i = 0; i < 14; i++) step();
      check_val("bp_grants", 32'(grant_log.size() - g0), 32'd4);
      check_bit("bp_req_held", s_req, 1'b0);
      check_bit("bp_full_valid", s_valid, 1'b1);
      inst_ready_i = 1'b1;
      p0 = pops; g0 = grant_log.size();
      for (int i = 0; i < 24; i++) step();
      check_val("bp_pops", 32'(pops - p0), 32'd24);
      check_val("bp_refill", 32'(grant_log.size() - g0), 32'd23);

      // Latency 3, redirect with two fetches outstanding.
      lat = 3; mem_gnt_i = 1'b0;
      do_reset(2);
      step(); step();
      mem_gnt_i = 1'b1;
      step(); step();
      mem_gnt_i = 1'b0;
      check_val("flush_outstanding", 32'(pend_q.size()), 32'd2);
      redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
      step();
      redirect_i = 1'b0; mem_gnt_i = 1'b1; seen_pop = 1'b0;
      step();
      check_bit("flush_valid_low", s_valid, 1'b0);
      for (int i = 0; i < 20; i++) step();
      check_bit("flush_seen", seen_pop, 1'b1);
      check_val("flush_first_pc", first_pc, 32'h8000_0100);
      check_val("flush_first_inst", first_inst, mem_word(32'h8000_0100));
`ifdef IFETCH_PERF_EN
      check_val("perf_flush", perf_flush_cnt_o, 32'd1);
      check_val("perf_drop", perf_drop_cnt_o, 32'd2);
      do_reset(2);
      check_val("perf_flush_rst", perf_flush_cnt_o, 32'd0);
      check_val("perf_drop_rst", perf_drop_cnt_o, 32'd0);
      check_val("perf_stall_rst", perf_stall_cnt_o, 32'd0);
`endif

      // Redirect coinciding with a response and a consumer handshake.
      lat = 2; mem_gnt_i = 1'b1; inst_ready_i = 1'b1;
      do_reset(2);
      for (int i = 0; i < 12; i++) step();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (pend_q.size() > 0 && pend_q[0].due <= cyc && fifo_m() > 0) found = 1'b1;
         else step();
      end
      check_bit("coinc_setup", found, 1'b1);
      disc_exp = pend_q.size() - 1;
`ifdef IFETCH_PERF_EN
      drop0 = perf_drop_cnt_o;
`endif
      p0 = pops;
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_1236;
      step();
      redirect_i = 1'b0; seen_pop = 1'b0;
      check_val("coinc_hs_taken", 32'(pops - p0), 32'd1);
      step();
      check_bit("coinc_valid_low", s_valid, 1'b0);
      for (int i = 0; i < 15; i++) step();
      check_val("coinc_first_pc", first_pc, 32'h0000_1234);
      check_val("coinc_first_inst", first_inst, mem_word(32'h0000_1234));
`ifdef IFETCH_PERF_EN
      check_val("coinc_drops", perf_drop_cnt_o - drop0, 32'(disc_exp + 1));
`else
      check_bit("coinc_disc_pos", disc_exp > 0, 1'b1);
`endif

      // Address wrap-around.
      lat = 1;
      for (int i = 0; i < 4; i++) step();
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      gl0 = grant_log.size();
      step();
      redirect_i = 1'b0; seen_pop = 1'b0;
      for (int i = 0; i < 10; i++) step();
      if (grant_log.size() >= gl0 + 3) begin
         check_val("wrap_addr0", grant_log[gl0], 32'hFFFF_FFFC);
         check_val("wrap_addr1", grant_log[gl0+1], 32'h0000_0000);
         check_val("wrap_addr2", grant_log[gl0+2], 32'h0000_0004);
      end else begin
         checks++; errors++;
         $display("FAIL wrap_grants: actual=%0d required>=3", grant_log.size() - gl0);
      end
      check_val("wrap_first_pc", first_pc, 32'hFFFF_FFFC);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
